cic_decim_r16: RTL and testbench

//  1-bit PDM -> multi-bit PCM CIC decimator (Hogenauer, N integrators + N combs, diff delay 1).

---
 rtl/cic_decim_r16.sv | 103 ++++++++++
 tb/tb_cic_decim_r16.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cic_decim_r16.sv
// cic_decim_r16: 1-bit PDM to multi-bit PCM Hogenauer CIC decimator.
// N integrators run at the PDM bit rate. An internal phase counter marks every
// R-th clock as a decimation tick, and only on that tick are the N combs
// (differential delay 1) evaluated.
// All sums use OW-bit wrap-around arithmetic. The comb output is exact because
// the true result never exceeds R**N, and R**N fits in OW bits.
module cic_decim_r16 #(
   parameter int N = 4,
   parameter int LOG2R = 4,
   localparam int OW = N * LOG2R + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          x_in,
   output logic [OW-1:0] y_out,
   output logic          y_valid
);

   localparam logic [LOG2R-1:0] PH_LAST = {LOG2R{1'b1}};
   localparam logic [LOG2R-1:0] PH_ONE  = {{(LOG2R-1){1'b0}}, 1'b1};

   logic [OW-1:0]    integ_r    [N];
   logic [OW-1:0]    comb_dly_r [N];
   logic [OW-1:0]    comb_s     [N+1];
   logic [LOG2R-1:0] ph_r;
   logic             tick_s;

   // Phase counter: free-running modulo-R count that locates the decimation tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_r <= {LOG2R{1'b0}};
      end else begin
         ph_r <= ph_r + PH_ONE;
      end
   end

   // Tick decode: the last phase of each R-clock frame
   always_comb begin
      tick_s = 1'b0;
      if (ph_r == PH_LAST) begin
         tick_s = 1'b1;
      end else begin
         tick_s = 1'b0;
      end
   end

   // Integrator cascade: accumulates every clock; each stage uses the previous stage's old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            integ_r[k] <= {OW{1'b0}};
         end
      end else begin
         integ_r[0] <= integ_r[0] + {{(OW-1){1'b0}}, x_in};
         for (int k = 1; k < N; k++) begin
            integ_r[k] <= integ_r[k] + integ_r[k-1];
         end
      end
   end

   // Comb chain: combinational differences from the last integrator to the output
   always_comb begin
      for (int k = 0; k <= N; k++) begin
         comb_s[k] = {OW{1'b0}};
      end
      comb_s[0] = integ_r[N-1];
      for (int k = 0; k < N; k++) begin
         comb_s[k+1] = comb_s[k] - comb_dly_r[k];
      end
   end

   // Comb delay registers: each captures its stage input only on a decimation tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            comb_dly_r[k] <= {OW{1'b0}};
         end
      end else if (tick_s) begin
         for (int k = 0; k < N; k++) begin
            comb_dly_r[k] <= comb_s[k];
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            comb_dly_r[k] <= comb_dly_r[k];
         end
      end
   end

   // Output register: loads the comb result and pulses the strobe once per tick; otherwise holds the sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_out   <= {OW{1'b0}};
         y_valid <= 1'b0;
      end else if (tick_s) begin
         y_out   <= comb_s[N];
         y_valid <= 1'b1;
      end else begin
         y_out   <= y_out;
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cic_decim_r16.sv
// tb_cic_decim_r16: scoreboard bench for the R=16, N=4 CIC decimator.
// The stimulus side pushes one expected entry per decimation tick. A monitor
// pops and checks an entry on every y_valid strobe. The monitor also checks
// that strobes are spaced 16 clocks apart and never appear during reset.
// Ramp values are the 4th backward difference, with step 16, of C(16k-1, 4).
// Steady values for a period-p pattern are 16**4 / p.
module tb_cic_decim_r16;

   typedef struct packed {
      logic        chk;
      logic [16:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        x_in = 1'b0;
   logic [16:0] y_out;
   logic        y_valid;

   int   total = 0;
   int   bad = 0;
   int   gap = 0;
   exp_t sb_q[$];
   logic [16:0] ramp [5] = '{17'd1365, 17'd26005, 17'd60695, 17'd65535, 17'd65536};

   cic_decim_r16 dut (
      .clk    (clk),
      .rst    (rst),
      .x_in   (x_in),
      .y_out  (y_out),
      .y_valid(y_valid)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   // Monitor: samples 1 unit after each rising edge; checks strobe spacing and scoreboard entries
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         gap = 0;
         total++;
         if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL strobe_in_reset got=%b want=0", y_valid);
         end
      end else begin
         gap++;
         if (y_valid === 1'b1) begin
            total++;
            if (gap != 16) begin
               bad++;
               $display("FAIL strobe_gap got=%0d want=16", gap);
            end
            gap = 0;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe y_out=%0d", y_out);
            end else begin
               e = sb_q.pop_front();
               if (e.chk) begin
                  total++;
                  if (y_out !== e.val) begin
                     bad++;
                     $display("FAIL y_out got=%0d want=%0d at %0t", y_out, e.val, $time);
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic push_n(input logic chk, input logic [16:0] val, input int n);
      exp_t e;
      e.chk = chk;
      e.val = val;
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   task automatic push_ramp();
      exp_t e;
      e.chk = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e.val = ramp[i];
         sb_q.push_back(e);
      end
   endtask

   task automatic step(input logic b);
      x_in = b;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      x_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Stimulus: directed test sequence, each segment queues its expectations before driving
   initial begin
      @(negedge clk);
      check("reset_y_out", y_out, 17'd0);
      check("reset_y_valid", {16'd0, y_valid}, 17'd0);

      // constant zero: every sample is 0
      do_reset();
      push_n(1'b1, 17'd0, 13);
      for (int i = 0; i < 208; i++) step(1'b0);

      // constant one: ramp, then full-scale 65536 long after the integrators wrap
      do_reset();
      push_ramp();
      push_n(1'b1, 17'd65536, 251);
      for (int i = 0; i < 4096; i++) step(1'b1);

      // alternating 1,0: steady value is half scale
      do_reset();
      push_n(1'b0, 17'd0, 4);
      push_n(1'b1, 17'd32768, 8);
      for (int i = 0; i < 192; i++) step((i % 2) == 0);

      // one bit in four: steady quarter scale, then zero input decays to 0 by the 5th tick
      do_reset();
      push_n(1'b0, 17'd0, 4);
      push_n(1'b1, 17'd16384, 6);
      for (int i = 0; i < 160; i++) step((i % 4) == 0);
      push_n(1'b0, 17'd0, 4);
      push_n(1'b1, 17'd0, 3);
      for (int i = 0; i < 112; i++) step(1'b0);

      // async reset mid-run, asserted just after a strobe, then restart
      do_reset();
      push_ramp();
      push_n(1'b1, 17'd65536, 1);
      for (int i = 0; i < 96; i++) step(1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_y_out", y_out, 17'd0);
      check("async_rst_y_valid", {16'd0, y_valid}, 17'd0);
      do_reset();
      push_ramp();
      push_n(1'b1, 17'd65536, 3);
      for (int i = 0; i < 128; i++) step(1'b1);

      // drain: every queued expectation must have been consumed by a strobe
      repeat (4) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL pending_entries got=%0d want=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
